// File: rtl/fft_pkg.sv
// Shared constants and helpers for the elastic FFT pipeline register.
package fft_pkg;

  localparam int W_DEF     = 15;
  localparam int LANES_DEF = 32;

  // Extract lane k from a packed vector (default geometry).
  function automatic logic [W_DEF-1:0] lane_get(input logic [LANES_DEF*W_DEF-1:0] v,
                                                input int k);
    return v[k*W_DEF +: W_DEF];
  endfunction

  // Return v with lane k replaced by x (default geometry).
  function automatic logic [LANES_DEF*W_DEF-1:0] lane_set(input logic [LANES_DEF*W_DEF-1:0] v,
                                                          input int k,
                                                          input logic [W_DEF-1:0] x);
    logic [LANES_DEF*W_DEF-1:0] r;
    r = v;
    r[k*W_DEF +: W_DEF] = x;
    return r;
  endfunction

  // Count set bits; callers zero-extend their valid vector to 32 bits.
  function automatic logic [5:0] popcount(input logic [31:0] x);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, x[i]};
    return c;
  endfunction

endpackage

// File: rtl/fft_pipe_slice.sv
// One elastic register stage: valid bit plus payload, ready passed upstream
// combinationally so a full chain still streams one beat per cycle.
module fft_pipe_slice import fft_pkg::*; #(
  parameter int PW = 2 + 2 * LANES_DEF * W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          up_valid,
  input  logic [PW-1:0] up_data,
  input  logic          dn_ready,
  output logic          valid,
  output logic [PW-1:0] data,
  output logic          rdy
);

  logic          v_q, v_d;
  logic [PW-1:0] d_q;

  // Stage can take a new beat when empty or when its beat moves on.
  assign rdy   = !v_q | dn_ready;
  assign valid = v_q;
  assign data  = d_q;

  // Next valid: flush empties the stage, otherwise follow upstream on load.
  always_comb begin
    v_d = v_q;
    if (flush)    v_d = 1'b0;
    else if (rdy) v_d = up_valid;
  end

  // Valid register; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) v_q <= 1'b0;
    else     v_q <= v_d;
  end

  // Payload only clocks on a real load, so idle/stalled data stays put.
  always_ff @(posedge clk) begin
    if (rst)                              d_q <= '0;
    else if (!flush && rdy && up_valid)   d_q <= up_data;
  end

endmodule

// File: rtl/fft_pipe_elastic.sv
// Parametrised elastic pipeline register for LANES complex samples with
// frame tags, synchronous flush and an occupancy count.
module fft_pipe_elastic import fft_pkg::*; #(
  parameter int W     = W_DEF,
  parameter int LANES = LANES_DEF,
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sof,
  input  logic               in_eof,
  input  logic [LANES*W-1:0] d_r,
  input  logic [LANES*W-1:0] d_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sof,
  output logic               out_eof,
  output logic [LANES*W-1:0] q_r,
  output logic [LANES*W-1:0] q_i,
  output logic [CNT_W-1:0]   occupancy
);

  localparam int PW = 2 + 2 * LANES * W;

  // vin[s] is the valid entering stage s; vin[s+1] is stage s's own valid.
  logic [DEPTH:0] vin;
  logic [DEPTH:0] rdy;
  logic [PW-1:0]  pl [DEPTH+1];

  assign vin[0]     = in_valid & !flush;
  assign pl[0]      = {in_sof, in_eof, d_r, d_i};
  assign rdy[DEPTH] = out_ready;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    fft_pipe_slice #(.PW(PW)) u_slice (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (vin[s]),
      .up_data  (pl[s]),
      .dn_ready (rdy[s+1]),
      .valid    (vin[s+1]),
      .data     (pl[s+1]),
      .rdy      (rdy[s])
    );
  end

  assign in_ready  = rdy[0] & !flush;
  assign out_valid = vin[DEPTH];
  assign {out_sof, out_eof, q_r, q_i} = pl[DEPTH];
  assign occupancy = CNT_W'(popcount(32'(vin[DEPTH:1])));

endmodule

// File: tb/tb_fft_pipe_elastic.sv
// Bench for fft_pipe_elastic: directed scenarios on a DEPTH=2/LANES=32
// instance plus randomized framed traffic across a depth/lane sweep,
// checked against a queue-based model of an in-order elastic FIFO.
module tb_fft_pipe_elastic;
  import fft_pkg::*;

  localparam int NI = 4;

  function automatic int dep_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      2:       return 3;
      default: return 8;
    endcase
  endfunction

  function automatic int ln_of(input int g);
    return (g == 0 || g == 2) ? 32 : 1;
  endfunction

  typedef struct {
    logic         sof;
    logic         eof;
    logic [479:0] r;
    logic [479:0] i;
    int           c;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         t_flush[NI], t_in_valid[NI], t_sof[NI], t_eof[NI], t_out_ready[NI];
  logic [479:0] t_dr[NI], t_di[NI];
  logic         o_in_ready[NI], o_out_valid[NI], o_sof[NI], o_eof[NI];
  logic [479:0] o_qr[NI], o_qi[NI];
  logic [3:0]   o_occ[NI];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = ln_of(g);
    localparam int D = dep_of(g);
    logic [L*15-1:0] qr, qi;
    fft_pipe_elastic #(.W(15), .LANES(L), .DEPTH(D), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst), .flush(t_flush[g]),
      .in_valid(t_in_valid[g]), .in_ready(o_in_ready[g]),
      .in_sof(t_sof[g]), .in_eof(t_eof[g]),
      .d_r(t_dr[g][L*15-1:0]), .d_i(t_di[g][L*15-1:0]),
      .out_valid(o_out_valid[g]), .out_ready(t_out_ready[g]),
      .out_sof(o_sof[g]), .out_eof(o_eof[g]),
      .q_r(qr), .q_i(qi), .occupancy(o_occ[g]));
    assign o_qr[g] = 480'(qr);
    assign o_qi[g] = 480'(qi);
  end

  task automatic idle_all();
    for (int i = 0; i < NI; i++) begin
      t_flush[i] = 1'b0; t_in_valid[i] = 1'b0; t_sof[i] = 1'b0; t_eof[i] = 1'b0;
      t_out_ready[i] = 1'b1; t_dr[i] = '0; t_di[i] = '0;
    end
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({o_out_valid[i], o_sof[i], o_eof[i], o_occ[i]} !== 7'd0 || o_qr[i] !== '0 || o_qi[i] !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst %0d got ov=%0b sof=%0b eof=%0b occ=%0d qr0=%h want all 0",
                 i, o_out_valid[i], o_sof[i], o_eof[i], o_occ[i], o_qr[i][14:0]);
      end
      checks++;
      if (o_in_ready[i] !== 1'b1) begin
        errors++; $display("FAIL reset_in_ready inst %0d got %0b want 1", i, o_in_ready[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    int exp_occ;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      t_in_valid[0] = (k < 4);
      t_dr[0] = '0;
      t_dr[0][14:0] = 15'(k + 1);
      #1;
      exp_occ = ((k < 4) ? k : 4) - ((k > 2) ? k - 2 : 0);
      checks++;
      if (o_in_ready[0] !== 1'b1) begin
        errors++; $display("FAIL stream_in_ready cyc %0d got %0b want 1", k, o_in_ready[0]);
      end
      checks++;
      if (o_occ[0] !== 4'(exp_occ)) begin
        errors++; $display("FAIL stream_occ cyc %0d got %0d want %0d", k, o_occ[0], exp_occ);
      end
      checks++;
      if (o_out_valid[0] !== (k >= 2)) begin
        errors++; $display("FAIL stream_out_valid cyc %0d got %0b want %0b", k, o_out_valid[0], k >= 2);
      end
      if (k >= 2) begin
        checks++;
        if (o_qr[0][14:0] !== 15'(k - 1)) begin
          errors++; $display("FAIL stream_q_r cyc %0d got %0d want %0d", k, o_qr[0][14:0], k - 1);
        end
      end
      @(negedge clk);
    end
    idle_all();
  endtask

  task automatic test_sign();
    logic [479:0] er, ei;
    int sv;
    do_reset();
    er = lane_set('0, 0, 15'h3FFF);
    ei = lane_set('0, 31, 15'h4000);
    t_dr[0] = er; t_di[0] = ei; t_in_valid[0] = 1'b1;
    @(negedge clk);
    idle_all();
    @(negedge clk);
    #1;
    checks++;
    if (o_out_valid[0] !== 1'b1 || o_qr[0] !== er || o_qi[0] !== ei) begin
      errors++;
      $display("FAIL sign_packing got ov=%0b qr_l0=%h qi_l31=%h want ov=1 qr_l0=3fff qi_l31=4000 others 0",
               o_out_valid[0], lane_get(o_qr[0], 0), lane_get(o_qi[0], 31));
    end
    sv = $signed(lane_get(o_qi[0], 31));
    checks++;
    if (sv != -16384) begin
      errors++; $display("FAIL sign_value got %0d want -16384", sv);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int nxt = 0;
    int got[$];
    do_reset();
    t_out_ready[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      t_in_valid[0] = (nxt < 3);
      t_dr[0] = '0; t_dr[0][14:0] = 15'(10 + nxt);
      #1;
      if (k >= 2) begin
        checks++;
        if (o_in_ready[0] !== 1'b0 || o_occ[0] !== 4'd2) begin
          errors++; $display("FAIL bp_stall cyc %0d got in_ready=%0b occ=%0d want 0/2", k, o_in_ready[0], o_occ[0]);
        end
      end
      if (t_in_valid[0] && o_in_ready[0]) nxt++;
      @(negedge clk);
    end
    checks++;
    if (nxt != 2) begin
      errors++; $display("FAIL bp_accepted got %0d want 2", nxt);
    end
    t_out_ready[0] = 1'b1;
    for (int k = 0; k < 20 && got.size() < 3; k++) begin
      t_in_valid[0] = (nxt < 3);
      t_dr[0] = '0; t_dr[0][14:0] = 15'(10 + nxt);
      #1;
      if (o_out_valid[0]) got.push_back(int'(o_qr[0][14:0]));
      if (t_in_valid[0] && o_in_ready[0]) nxt++;
      @(negedge clk);
    end
    t_in_valid[0] = 1'b0;
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL bp_delivered got %0d beats want 3", got.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (got[j] != 10 + j) begin
          errors++; $display("FAIL bp_order beat %0d got %0d want %0d", j, got[j], 10 + j);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (o_out_valid[0] !== 1'b0) begin
        errors++; $display("FAIL bp_duplicate cyc %0d got out_valid=%0b want 0", k, o_out_valid[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    do_reset();
    t_out_ready[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t_in_valid[0] = 1'b1; t_dr[0] = '0; t_dr[0][14:0] = 15'(20 + k);
      @(negedge clk);
    end
    t_in_valid[0] = 1'b0;
    #1;
    checks++;
    if (o_occ[0] !== 4'd2) begin
      errors++; $display("FAIL flush_prefill_occ got %0d want 2", o_occ[0]);
    end
    t_flush[0] = 1'b1; t_in_valid[0] = 1'b1; t_dr[0][14:0] = 15'd99; t_out_ready[0] = 1'b1;
    #1;
    checks++;
    if (o_in_ready[0] !== 1'b0) begin
      errors++; $display("FAIL flush_in_ready got %0b want 0", o_in_ready[0]);
    end
    @(negedge clk);
    t_flush[0] = 1'b0; t_in_valid[0] = 1'b0;
    #1;
    checks++;
    if (o_out_valid[0] !== 1'b0 || o_occ[0] !== 4'd0) begin
      errors++; $display("FAIL flush_after got ov=%0b occ=%0d want 0/0", o_out_valid[0], o_occ[0]);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      if (o_out_valid[0] === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_dropped_beat got %0d emitted beats want 0", seen);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_stall();
    do_reset();
    t_out_ready[0] = 1'b0;
    t_in_valid[0] = 1'b1; t_sof[0] = 1'b1; t_dr[0][14:0] = 15'd5; t_di[0][59:45] = 15'h1234;
    @(negedge clk);
    t_sof[0] = 1'b0; t_eof[0] = 1'b1; t_dr[0][14:0] = 15'd6;
    @(negedge clk);
    idle_all(); t_out_ready[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({o_out_valid[0], o_sof[0], o_eof[0], o_occ[0]} !== 7'd0 || o_qr[0] !== '0 || o_qi[0] !== '0) begin
      errors++;
      $display("FAIL rst_stall_outputs got ov=%0b sof=%0b eof=%0b occ=%0d qr_l0=%h want all 0",
               o_out_valid[0], o_sof[0], o_eof[0], o_occ[0], o_qr[0][14:0]);
    end
    t_out_ready[0] = 1'b1; t_in_valid[0] = 1'b1; t_sof[0] = 1'b1; t_dr[0][14:0] = 15'd7;
    @(negedge clk);
    idle_all();
    @(negedge clk);
    #1;
    checks++;
    if (o_out_valid[0] !== 1'b1 || o_sof[0] !== 1'b1 || o_eof[0] !== 1'b0 || o_qr[0][14:0] !== 15'd7) begin
      errors++;
      $display("FAIL rst_restart got ov=%0b sof=%0b eof=%0b qr_l0=%0d want 1/1/0/7",
               o_out_valid[0], o_sof[0], o_eof[0], o_qr[0][14:0]);
    end
    @(negedge clk);
  endtask

  // Two 4-beat frames with random gaps and random backpressure; the model
  // is an in-order queue where a beat is visible DEPTH cycles after accept.
  task automatic test_tags(input int idx);
    beat_t        q[$];
    beat_t        b;
    logic [479:0] m;
    logic         exp_ov, exp_rdy;
    int           d = dep_of(idx);
    int           sent = 0, got = 0, cyc = 0;
    do_reset();
    m = (ln_of(idx) == 32) ? '1 : 480'h7FFF;
    while (got < 8 && cyc < 400) begin
      t_in_valid[idx] = (sent < 8) && ($urandom_range(0, 3) != 0);
      t_sof[idx] = (sent % 4 == 0);
      t_eof[idx] = (sent % 4 == 3);
      for (int w = 0; w < 15; w++) begin
        t_dr[idx][w*32 +: 32] = $urandom();
        t_di[idx][w*32 +: 32] = $urandom();
      end
      t_dr[idx] = t_dr[idx] & m;
      t_di[idx] = t_di[idx] & m;
      t_out_ready[idx] = 1'($urandom_range(0, 1));
      #1;
      exp_ov  = (q.size() > 0) && (cyc >= q[0].c + d);
      exp_rdy = (q.size() < d) || t_out_ready[idx];
      checks++;
      if (o_out_valid[idx] !== exp_ov || o_in_ready[idx] !== exp_rdy || o_occ[idx] !== 4'(q.size())) begin
        errors++;
        $display("FAIL tags_ctrl inst %0d cyc %0d got ov=%0b rdy=%0b occ=%0d want ov=%0b rdy=%0b occ=%0d",
                 idx, cyc, o_out_valid[idx], o_in_ready[idx], o_occ[idx], exp_ov, exp_rdy, q.size());
      end
      if (exp_ov) begin
        checks++;
        if (o_sof[idx] !== q[0].sof || o_eof[idx] !== q[0].eof || o_qr[idx] !== q[0].r || o_qi[idx] !== q[0].i) begin
          errors++;
          $display("FAIL tags_beat inst %0d cyc %0d got sof=%0b eof=%0b qr_l0=%h want sof=%0b eof=%0b qr_l0=%h",
                   idx, cyc, o_sof[idx], o_eof[idx], o_qr[idx][14:0], q[0].sof, q[0].eof, q[0].r[14:0]);
        end
        if (t_out_ready[idx]) begin
          void'(q.pop_front());
          got++;
        end
      end
      if (t_in_valid[idx] && exp_rdy) begin
        b.sof = t_sof[idx]; b.eof = t_eof[idx]; b.r = t_dr[idx]; b.i = t_di[idx]; b.c = cyc;
        q.push_back(b);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (got != 8) begin
      errors++; $display("FAIL tags_timeout inst %0d got %0d beats want 8", idx, got);
    end
    idle_all();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_stream();
    test_sign();
    test_backpressure();
    test_flush();
    test_reset_stall();
    for (int g = 0; g < NI; g++) test_tags(g);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
